truth_table_checker: RTL
========================

Name: truth_table_checker

Overview:
- Synthesizable on-chip counterpart of the gate-level truth-table benches: it walks all 2^N_IN input combinations, drives them into a combinational DUT, samples the DUT output and compares it against an expected truth table.
- Reports per-row results, a mismatch count, the first failing row, and a final pass/fail.
- Sits beside any gate under test (Xor, And, Mux, ...) on the FPGA, so gate verification runs in hardware without a simulator.

Parameters:
- N_IN, 2, number of DUT input bits; rows = 2^N_IN; legal range 1..8.
- SETTLE, 1, idle cycles between applying a row and sampling it; legal range 0..15.
- EXPECTED, 4'b0110, width 2^N_IN; bit k is the expected DUT output for input value k (default = Xor).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- dut_in  out  N_IN  registered stimulus to the DUT inputs (bit 0 = LSB input, e.g. b; MSB = a).
- dut_out  in  1  DUT output, treated as synchronous to clk.
- busy  out  1  high from the start-accept edge until done rises.
- row_valid  out  1  one-cycle strobe, one per row, in ascending row order.
- row_idx  out  N_IN  row index for the current row_valid.
- row_got  out  1  sampled dut_out for that row.
- row_ok  out  1  row_got == EXPECTED[row_idx].
- err_count  out  N_IN+1  saturating-free mismatch count (max 2^N_IN fits).
- first_err_valid  out  1  at least one mismatch seen this run.
- first_err_idx  out  N_IN  index of the lowest mismatching row; 0 when first_err_valid=0.
- done  out  1  held high after the last row until the next accepted start or reset.
- pass  out  1  valid while done=1: err_count==0; 0 otherwise.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; every output 0, including dut_in.
  - Reset mid-run aborts immediately and leaves no residual counts.
- States:
  - IDLE: wait for start.
  - WAIT: settle countdown.
  - SAMPLE: compare and advance.
  - DONE: results held.
- IDLE/DONE with start=1 (edge E0):
  - idx←0, dut_in←0, cnt←SETTLE.
  - err_count, first_err_*, done, pass, row_valid all cleared.
  - busy←1, state←WAIT.
- WAIT: if cnt≠0 then cnt←cnt−1, else go to SAMPLE on the same edge. SAMPLE is a combinational decision within the WAIT cnt==0 cycle, not an extra cycle.
- Sample edge for row idx:
  - row_valid←1, row_idx←idx, row_got←dut_out, row_ok←(dut_out==EXPECTED[idx]).
  - On mismatch: err_count+1; if first_err_valid=0, also first_err_idx←idx and first_err_valid←1.
- After the sample edge:
  - If idx<2^N_IN−1: idx←idx+1, dut_in←idx+1, cnt←SETTLE, stay in WAIT.
  - If idx==2^N_IN−1: state←DONE, done←1, busy←0, pass←(final err_count==0). The final count includes the last row's result, computed same-edge.
- row_valid is high for exactly one cycle per row; it is 0 in IDLE and DONE.
- Timing:
  - Each row occupies SETTLE+1 cycles.
  - Row k is sampled at edge E0+(k+1)(SETTLE+1).
  - done rises at edge E0+2^N_IN·(SETTLE+1).
  - dut_in is stable for the whole WAIT interval of its row.
- start while busy: ignored, no effect on the run.
- start in DONE: restarts the run; results are cleared at the accept edge.
- dut_in holds the last row value in DONE.

Decomposition:
- Shared package checker_pkg:
  - state enum (IDLE, WAIT, DONE), 2-bit encoding.
  - SETTLE_W=4 constant.
  - function rows(n)=1<<n.
- One natural sub-module: settle_timer, a loadable down-counter with a zero flag driving the WAIT→sample decision.
- The rest is a single FSM plus score registers.

Test Plan:
- Xor DUT, N_IN=2, SETTLE=1, EXPECTED=4'b0110, start pulse:
  - row_valid ×4 with row_idx 0,1,2,3 and row_got 0,1,1,0, all row_ok=1.
  - done at E0+8, pass=1, err_count=0, first_err_valid=0.
- And DUT with EXPECTED=4'b0110:
  - row_got 0,0,0,1; row_ok 1,0,0,0.
  - err_count=3, first_err_idx=1, first_err_valid=1, pass=0, done=1.
- Reset mid-run (rst_n low during row 2 WAIT, Xor DUT):
  - All outputs 0 asynchronously; state IDLE.
  - A new start yields a clean pass with err_count=0.
- start pulsed at row 1 while busy:
  - Ignored; row sequence and done time unchanged (E0+8).
  - start in DONE restarts the run, clearing done/err_count on the accept edge.
- N_IN=3, SETTLE=0, EXPECTED=8'hFF, dut_out tied 1:
  - 8 consecutive row_valid cycles, rows 0..7.
  - done at E0+8, pass=1.
- Same configuration with dut_out tied 0:
  - err_count=8 (full width, no wrap), first_err_idx=0.

Source files
------------

// File: rtl/checker_pkg.sv
// checker_pkg: shared state encoding, settle-counter width and row-count helper.
package checker_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int SETTLE_W = 4;
    function automatic int rows(input int n);
        return 1 << n;
    endfunction
endpackage

// File: rtl/truth_table_checker_settle.sv
// settle_timer: loadable down-counter whose zero flag marks the sample cycle of a row.
import checker_pkg::*;
module settle_timer (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic                zero
);
    logic [SETTLE_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: walks every input row of a combinational DUT and scores it against EXPECTED.
import checker_pkg::*;
module truth_table_checker #(
    parameter int N_IN = 2,
    parameter int SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b0110
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            row_valid,
    output logic [N_IN-1:0] row_idx,
    output logic            row_got,
    output logic            row_ok,
    output logic [N_IN:0]   err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_idx,
    output logic            done,
    output logic            pass
);
    localparam logic [N_IN-1:0] LAST = N_IN'(rows(N_IN) - 1);
    state_t state;
    logic zero, ok, last, accept, sample;
    // dut_in doubles as the row index: it always holds the row being settled
    assign ok     = dut_out == EXPECTED[dut_in];
    assign last   = dut_in == LAST;
    assign accept = start && state != WAIT;
    assign sample = state == WAIT && zero;
    settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept || (sample && !last)),
        .load_val (SETTLE_W'(SETTLE)),
        .en       (state == WAIT),
        .zero     (zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            dut_in          <= '0;
            busy            <= 1'b0;
            row_valid       <= 1'b0;
            row_idx         <= '0;
            row_got         <= 1'b0;
            row_ok          <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            row_valid <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state           <= WAIT;
                    dut_in          <= '0;
                    busy            <= 1'b1;
                    err_count       <= '0;
                    first_err_valid <= 1'b0;
                    first_err_idx   <= '0;
                    done            <= 1'b0;
                    pass            <= 1'b0;
                end
                WAIT: if (zero) begin
                    row_valid <= 1'b1;
                    row_idx   <= dut_in;
                    row_got   <= dut_out;
                    row_ok    <= ok;
                    if (!ok) begin
                        err_count <= err_count + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= dut_in;
                        end
                    end
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= ok && err_count == '0;
                    end else begin
                        dut_in <= dut_in + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
